// File: rtl/pipeline_pkg.sv
// Shared widths and the write-request struct for the pipeline back end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_array.sv
// 32 x DATA_W register storage: one synchronous write port, two asynchronous read ports, x0 reads zero.
// Latency: write lands on the next rising edge; reads are combinational.
// Backpressure: none; a write to x0 is silently dropped.
module regfile_array
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != ZERO_REG)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == ZERO_REG) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == ZERO_REG) ? '0 : regs[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB register, register-file commit and ID read ports (bypass under WB_REGFILE_BYPASS_EN).
// Latency: request captured on edge N, committed on edge N+1; reads are combinational.
// Backpressure: stall_i holds MEM/WB (commit repeats idempotently); flush_i loads a bubble and beats stall.
module wb_regfile
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_reg_en_i,
    input  logic [ADDR_W-1:0] write_reg_addr_i,
    input  logic [DATA_W-1:0] write_reg_data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              wb_en_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o
);
    wb_req_t           mem_req;
    wb_req_t           wb_q;
    logic [DATA_W-1:0] arr_rdata1;
    logic [DATA_W-1:0] arr_rdata2;
    logic              byp1;
    logic              byp2;

    assign mem_req = '{en: write_reg_en_i, addr: write_reg_addr_i, data: write_reg_data_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else if (flush_i) begin
            wb_q <= '0;
        end else if (!stall_i) begin
            wb_q <= mem_req;
        end
    end

    regfile_array u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_q.en),
        .waddr  (wb_q.addr),
        .wdata  (wb_q.data),
        .raddr1 (raddr1_i),
        .raddr2 (raddr2_i),
        .rdata1 (arr_rdata1),
        .rdata2 (arr_rdata2)
    );

`ifdef WB_REGFILE_BYPASS_EN
    // A hit serves the value being committed this cycle, saving the hazard unit one stall.
    assign byp1 = wb_q.en && (wb_q.addr != ZERO_REG) && (wb_q.addr == raddr1_i);
    assign byp2 = wb_q.en && (wb_q.addr != ZERO_REG) && (wb_q.addr == raddr2_i);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (re1_i && (raddr1_i != ZERO_REG)) begin
            rdata1_o = byp1 ? wb_q.data : arr_rdata1;
        end
        if (re2_i && (raddr2_i != ZERO_REG)) begin
            rdata2_o = byp2 ? wb_q.data : arr_rdata2;
        end
    end

    assign wb_en_o   = wb_q.en;
    assign wb_addr_o = wb_q.addr;
    assign wb_data_o = wb_q.data;
endmodule
